tswitch_multicast_engine: RTL and testbench

Multicast write engine directly downstream of the command decoder.
- Accepts one dispatched CMD_STORE_MC request (node mask, address, data, tag, source port).
- Issues the write in parallel to every node in the mask and collects one ack per node.
- Returns a single completion (RESP_ACK, or RESP_ERROR) to the decoder for the response to the requesting port.
- One operation in flight; the decoder holds further multicasts until req_ready is high.

---
 rtl/tswitch_pkg.sv | 38 +++
 rtl/tswitch_multicast_engine.sv | 189 ++++++++++++++++++
 tb/tswitch_pkg_tb_note.sv | 3 +
 tb/tb_tswitch_multicast_engine.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/tswitch_pkg.sv
// Shared switch types: multicast FSM states, response codes, completion record,
// port sizing and a popcount helper.
package tswitch_pkg;

    localparam int NUM_PORTS          = 4;
    localparam int PORT_BITS          = $clog2(NUM_PORTS);
    localparam int TAG_WIDTH          = 8;
    localparam int MC_TIMEOUT_DEFAULT = 1024;

    typedef enum logic [1:0] {
        MC_IDLE    = 2'd0,
        MC_WRITING = 2'd1,
        MC_WAITING = 2'd2,
        MC_DONE    = 2'd3
    } multicast_state_t;

    typedef enum logic [1:0] {
        RESP_ACK   = 2'd0,
        RESP_ERROR = 2'd1
    } resp_t;

    typedef struct packed {
        resp_t                 resp;
        logic [TAG_WIDTH-1:0]  tag;
        logic [PORT_BITS-1:0]  src_port;
    } mc_done_t;

    // Number of set bits in a per-port vector.
    function automatic logic [PORT_BITS:0] popcount(input logic [NUM_PORTS-1:0] v);
        logic [PORT_BITS:0] n;
        n = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            n = n + {{PORT_BITS{1'b0}}, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tswitch_multicast_engine.sv
// Multicast write engine: fans one store out to every node in a mask, collects
// one ack per node and returns a single completion to the command decoder.
// Optional ack timeout enabled by defining TSWITCH_MC_TIMEOUT_EN.
module tswitch_multicast_engine #(
    parameter int NUM_PORTS      = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 16,
    parameter int TAG_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int PORT_BITS     = $clog2(NUM_PORTS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [NUM_PORTS-1:0]  req_node_mask,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    input  logic [TAG_WIDTH-1:0]  req_tag,
    input  logic [PORT_BITS-1:0]  req_src_port,
    output logic [NUM_PORTS-1:0]  wr_valid,
    input  logic [NUM_PORTS-1:0]  wr_ready,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic [NUM_PORTS-1:0]  ack_valid,
    output logic                  done_valid,
    input  logic                  done_ready,
    output logic [1:0]            done_resp,
    output logic [TAG_WIDTH-1:0]  done_tag,
    output logic [PORT_BITS-1:0]  done_src_port,
    output logic [PORT_BITS:0]    outstanding
);
    import tswitch_pkg::*;

    multicast_state_t      state_q, state_d;
    logic [NUM_PORTS-1:0]  pending_wr_q, pending_wr_d;
    logic [NUM_PORTS-1:0]  pending_ack_q, pending_ack_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;
    logic [PORT_BITS-1:0]  src_q, src_d;
    resp_t                 resp_q, resp_d;
    logic [NUM_PORTS-1:0]  hs_s;
    logic [NUM_PORTS-1:0]  ack_ok_s;

`ifdef TSWITCH_MC_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic unused_timeout_s;
    assign unused_timeout_s = ^TIMEOUT_CYCLES;
`endif

    // Outputs come straight from state registers; pending_wr is only ever
    // nonzero while writing, so it doubles as the per-node write strobe.
    assign req_ready     = (state_q == MC_IDLE);
    assign done_valid    = (state_q == MC_DONE);
    assign wr_valid      = pending_wr_q;
    assign wr_addr       = addr_q;
    assign wr_data       = data_q;
    assign done_resp     = resp_q;
    assign done_tag      = tag_q;
    assign done_src_port = src_q;
    assign outstanding   = popcount(pending_ack_q);

    // Next-state logic: accept, write fan-out, ack collection, completion.
    always_comb begin
        state_d       = state_q;
        pending_wr_d  = pending_wr_q;
        pending_ack_d = pending_ack_q;
        addr_d        = addr_q;
        data_d        = data_q;
        tag_d         = tag_q;
        src_d         = src_q;
        resp_d        = resp_q;
        hs_s          = pending_wr_q & wr_ready;
        // An ack only counts once its node's write has been taken.
        ack_ok_s      = ack_valid & (~pending_wr_q | hs_s);
`ifdef TSWITCH_MC_TIMEOUT_EN
        cnt_d         = cnt_q;
`endif
        case (state_q)
            MC_IDLE: begin
                if (req_valid) begin
                    addr_d        = req_addr;
                    data_d        = req_data;
                    tag_d         = req_tag;
                    src_d         = req_src_port;
                    resp_d        = RESP_ACK;
                    pending_wr_d  = req_node_mask;
                    pending_ack_d = req_node_mask;
                    if (req_node_mask == '0) begin
                        state_d = MC_DONE;
                    end else begin
                        state_d = MC_WRITING;
                    end
                end else begin
                    state_d = MC_IDLE;
                end
            end
            MC_WRITING: begin
                pending_wr_d  = pending_wr_q & ~hs_s;
                pending_ack_d = pending_ack_q & ~ack_ok_s;
                if (pending_wr_d == '0) begin
                    if (pending_ack_d == '0) begin
                        state_d = MC_DONE;
                    end else begin
                        state_d = MC_WAITING;
                    end
                end else begin
                    state_d = MC_WRITING;
                end
            end
            MC_WAITING: begin
                pending_ack_d = pending_ack_q & ~ack_ok_s;
                if (pending_ack_d == '0) begin
                    state_d = MC_DONE;
                end else begin
                    state_d = MC_WAITING;
                end
            end
            MC_DONE: begin
                if (done_ready) begin
                    state_d = MC_IDLE;
                end else begin
                    state_d = MC_DONE;
                end
            end
            default: begin
                state_d       = MC_IDLE;
                pending_wr_d  = '0;
                pending_ack_d = '0;
            end
        endcase
`ifdef TSWITCH_MC_TIMEOUT_EN
        // Timeout loses to a completion landing in the same cycle.
        if (state_q == MC_IDLE) begin
            cnt_d = '0;
        end else if ((state_q == MC_WRITING) || (state_q == MC_WAITING)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if ((state_d != MC_DONE) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
                pending_wr_d  = '0;
                pending_ack_d = '0;
                resp_d        = RESP_ERROR;
                state_d       = MC_DONE;
            end else begin
                resp_d = resp_d;
            end
        end else begin
            cnt_d = cnt_q;
        end
`endif
    end

    // State and latched request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= MC_IDLE;
            pending_wr_q  <= '0;
            pending_ack_q <= '0;
            addr_q        <= '0;
            data_q        <= '0;
            tag_q         <= '0;
            src_q         <= '0;
            resp_q        <= RESP_ACK;
        end else begin
            state_q       <= state_d;
            pending_wr_q  <= pending_wr_d;
            pending_ack_q <= pending_ack_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            tag_q         <= tag_d;
            src_q         <= src_d;
            resp_q        <= resp_d;
        end
    end

`ifdef TSWITCH_MC_TIMEOUT_EN
    // Ack timeout cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tswitch_pkg_tb_note.sv
// Empty helper file intentionally left minimal: holds no logic.
module tswitch_tb_note_unused;
endmodule

// File: tb/tb_tswitch_multicast_engine.sv
// Self-checking bench for tswitch_multicast_engine: table of multicast
// operations with a completion scoreboard, plus reset and timeout sequences.
module tb_tswitch_multicast_engine;
    import tswitch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_node_mask;
    logic [31:0] req_addr;
    logic [15:0] req_data;
    logic [7:0]  req_tag;
    logic [1:0]  req_src_port;
    logic [3:0]  wr_valid;
    logic [3:0]  wr_ready;
    logic [31:0] wr_addr;
    logic [15:0] wr_data;
    logic [3:0]  ack_valid;
    logic        done_valid;
    logic        done_ready;
    logic [1:0]  done_resp;
    logic [7:0]  done_tag;
    logic [1:0]  done_src_port;
    logic [2:0]  outstanding;

    tswitch_multicast_engine #(
        .NUM_PORTS(4), .ADDR_WIDTH(32), .DATA_WIDTH(16), .TAG_WIDTH(8), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_node_mask(req_node_mask), .req_addr(req_addr), .req_data(req_data),
        .req_tag(req_tag), .req_src_port(req_src_port),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .ack_valid(ack_valid),
        .done_valid(done_valid), .done_ready(done_ready), .done_resp(done_resp),
        .done_tag(done_tag), .done_src_port(done_src_port), .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  mask;
        logic [31:0] addr;
        logic [15:0] data;
        logic [7:0]  tag;
        logic [1:0]  src;
        int          stall_node;
        int          stall;
        logic [3:0]  noack;
        logic [3:0]  inj;
        int          hold;
        resp_t       resp;
        int          out3;
    } op_t;

    int         errors = 0;
    int         checks = 0;
    mc_done_t   sb[$];
    int         stall_left = 0;
    logic [3:0] stall_bit = 4'b0000;
    logic [3:0] noack_mask = 4'b0000;
    logic [3:0] inject_next = 4'b0000;
    op_t        ops[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one cycle; node model acks one cycle after each accepted write.
    task automatic step();
        logic [3:0] hs;
        hs = wr_valid & wr_ready;
        @(posedge clk);
        #1;
        ack_valid   = (hs & ~noack_mask) | inject_next;
        inject_next = 4'b0000;
        if (stall_left > 0) stall_left--;
        wr_ready = (stall_left > 0) ? ~stall_bit : 4'b1111;
    endtask

    task automatic run_op(input op_t o);
        int       k;
        int       lat;
        mc_done_t e;
        noack_mask = o.noack;
        check("req_ready_before", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1; req_node_mask = o.mask; req_addr = o.addr;
        req_data = o.data; req_tag = o.tag; req_src_port = o.src;
        sb.push_back('{resp: o.resp, tag: o.tag, src_port: o.src});
        if (o.stall > 0) begin
            stall_bit  = 4'b0001 << o.stall_node;
            stall_left = o.stall + 1;
            wr_ready   = ~stall_bit;
        end else begin
            stall_bit = 4'b0000;
        end
        step();
        req_valid = 1'b0;
        for (k = 1; k <= 200; k++) begin
            if (k == 1) begin
                check("wr_valid_t1", {60'd0, wr_valid}, {60'd0, o.mask});
                check("outstanding_t1", {61'd0, outstanding}, {61'd0, popcount(o.mask)});
                check("wr_addr_t1", {32'd0, wr_addr}, {32'd0, o.addr});
                check("wr_data_t1", {48'd0, wr_data}, {48'd0, o.data});
            end
            if (k == 2 && o.stall > 0) begin
                check("wr_valid_stall", {60'd0, wr_valid}, {60'd0, stall_bit});
                check("wr_addr_stall", {32'd0, wr_addr}, {32'd0, o.addr});
                check("wr_data_stall", {48'd0, wr_data}, {48'd0, o.data});
            end
            if (k == 3 && o.out3 >= 0) begin
                check("outstanding_t3", {61'd0, outstanding}, 64'(o.out3));
            end
            if (done_valid) break;
            if (k == 1 || k == 2) inject_next = o.inj;
            step();
        end
        if (!done_valid) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no done_valid expected completion tag %0h", o.tag);
            sb.delete();
        end else begin
            if (o.noack == 4'b0000) begin
                if (o.mask == 4'b0000) lat = 1;
                else if (o.stall > 0 && o.mask[o.stall_node]) lat = 3 + o.stall;
                else lat = 3;
                check("latency", 64'(k), 64'(lat));
            end
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_empty: got completion expected none");
            end else begin
                e = sb.pop_front();
                check("done_resp", {62'd0, done_resp}, {62'd0, e.resp});
                check("done_tag", {56'd0, done_tag}, {56'd0, e.tag});
                check("done_src", {62'd0, done_src_port}, {62'd0, e.src_port});
            end
            check("outstanding_done", {61'd0, outstanding}, 64'd0);
            check("wr_valid_done", {60'd0, wr_valid}, 64'd0);
            for (int h = 0; h < o.hold; h++) begin
                step();
                check("hold_done_valid", {63'd0, done_valid}, 64'd1);
                check("hold_tag", {56'd0, done_tag}, {56'd0, o.tag});
                check("hold_req_ready", {63'd0, req_ready}, 64'd0);
            end
            done_ready = 1'b1;
            step();
            done_ready = 1'b0;
            check("done_cleared", {63'd0, done_valid}, 64'd0);
            check("req_ready_after", {63'd0, req_ready}, 64'd1);
        end
        noack_mask = 4'b0000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        op_t to_op;
        ops[0] = '{4'b1011, 32'h0000_1000, 16'h3F80, 8'h5A, 2'd2, 0, 0, 4'b0000, 4'b0000, 0, RESP_ACK, 0};
        ops[1] = '{4'b0110, 32'h0000_2000, 16'h4049, 8'h11, 2'd1, 1, 5, 4'b0000, 4'b0000, 0, RESP_ACK, 1};
        ops[2] = '{4'b1010, 32'h0000_3000, 16'hBF80, 8'h22, 2'd3, 3, 4, 4'b0000, 4'b1010, 0, RESP_ACK, 1};
        ops[3] = '{4'b0000, 32'h0000_4000, 16'h0001, 8'h33, 2'd0, 0, 0, 4'b0000, 4'b0000, 3, RESP_ACK, -1};
        ops[4] = '{4'b1111, 32'hFFFF_FFFC, 16'hFFFF, 8'hFF, 2'd3, 0, 0, 4'b0000, 4'b0000, 0, RESP_ACK, 0};
        ops[5] = '{4'b0001, 32'h0000_0000, 16'h0000, 8'h01, 2'd0, 0, 0, 4'b0000, 4'b0000, 1, RESP_ACK, 0};

        rst_n = 1'b0; req_valid = 1'b0; req_node_mask = 4'b0000; req_addr = 32'd0;
        req_data = 16'd0; req_tag = 8'd0; req_src_port = 2'd0; wr_ready = 4'b1111;
        ack_valid = 4'b0000; done_ready = 1'b0;
        #1;
        check("rst_req_ready", {63'd0, req_ready}, 64'd1);
        check("rst_wr_valid", {60'd0, wr_valid}, 64'd0);
        check("rst_done_valid", {63'd0, done_valid}, 64'd0);
        check("rst_done_resp", {62'd0, done_resp}, {62'd0, RESP_ACK});
        check("rst_outstanding", {61'd0, outstanding}, 64'd0);
        check("rst_wr_addr", {32'd0, wr_addr}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            run_op(ops[i]);
            step();
        end

        // Reset while waiting for an ack, then a late ack must be ignored.
        noack_mask = 4'b0001;
        req_valid = 1'b1; req_node_mask = 4'b0001; req_addr = 32'h0000_5000;
        req_data = 16'h1234; req_tag = 8'h77; req_src_port = 2'd1;
        step();
        req_valid = 1'b0;
        step();
        check("wait_outstanding", {61'd0, outstanding}, 64'd1);
        check("wait_wr_valid", {60'd0, wr_valid}, 64'd0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_req_ready", {63'd0, req_ready}, 64'd1);
        check("midrst_wr_valid", {60'd0, wr_valid}, 64'd0);
        check("midrst_outstanding", {61'd0, outstanding}, 64'd0);
        check("midrst_done_valid", {63'd0, done_valid}, 64'd0);
        check("midrst_wr_addr", {32'd0, wr_addr}, 64'd0);
        check("midrst_done_tag", {56'd0, done_tag}, 64'd0);
        #2 rst_n = 1'b1;
        noack_mask = 4'b0000;
        inject_next = 4'b0001;
        step();
        for (int j = 0; j < 3; j++) begin
            step();
            check("late_ack_done", {63'd0, done_valid}, 64'd0);
            check("late_ack_ready", {63'd0, req_ready}, 64'd1);
        end

`ifdef TSWITCH_MC_TIMEOUT_EN
        to_op = '{4'b0100, 32'h0000_6000, 16'h4000, 8'h66, 2'd2, 0, 0, 4'b0100, 4'b0000, 0, RESP_ERROR, -1};
        run_op(to_op);
        step();
        run_op(ops[0]);
`else
        to_op = ops[4];
        run_op(to_op);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
